addsub_pipe2: RTL

//  Two-stage pipelined WIDTH-bit adder/subtractor with valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/cla_lookahead4.sv | 21 ++
 rtl/addsub_pipe2.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined adder/subtractor: nibble size, the stage-1
// control struct and the 4-bit group generate/propagate function.
package alu_pkg;

    localparam int NIB = 4;

    // Per-bit g/p vectors are WIDTH-sized, so they sit next to this struct in the datapath.
    typedef struct packed {
        logic cin;
        logic a_msb;
        logic b_msb;
    } s1_t;

    function automatic logic [1:0] group_gp(input logic [NIB-1:0] g4, input logic [NIB-1:0] p4);
        logic grpG;
        logic grpP;
        grpG = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) | (p4[3] & p4[2] & p4[1] & g4[0]);
        grpP = &p4;
        return {grpG, grpP};
    endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// 4-bit carry lookahead cell: carry into each bit from a group carry-in,
// plus group generate/propagate.
module cla_lookahead4
    import alu_pkg::*;
(
    input  logic [NIB-1:0] g,
    input  logic [NIB-1:0] p,
    input  logic           c,
    output logic [NIB-1:0] C,
    output logic           G,
    output logic           P
);

    assign C[0] = c;
    assign C[1] = g[0] | (p[0] & c);
    assign C[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    assign C[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);

    assign {G, P} = group_gp(g, p);

endmodule

// File: rtl/addsub_pipe2.sv
// Two-stage pipelined adder/subtractor with valid/ready on both sides:
// stage 1 captures g/p and nibble G/P, stage 2 resolves carries, sum and flags.
module addsub_pipe2
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int NGRP = WIDTH / NIB;

    if (WIDTH % NIB != 0) begin : g_badWidth
        $error("addsub_pipe2: WIDTH (%0d) must be a multiple of 4", WIDTH);
    end

    logic             r_s1Valid;
    logic             r_outValid;
    logic             w_s1Adv;
    logic             w_s2Adv;

    logic [WIDTH-1:0] w_bMod;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [NGRP-1:0]  w_grpG;
    logic [NGRP-1:0]  w_grpP;

    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic [NGRP-1:0]  r_grpG;
    logic [NGRP-1:0]  r_grpP;
    s1_t              r_s1;

    logic [NGRP:0]    w_c;
    logic [WIDTH-1:0] w_bitC;
    logic [NGRP-1:0]  w_unusedG;
    logic [NGRP-1:0]  w_unusedP;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    assign w_s2Adv  = r_s1Valid & (!r_outValid | out_ready);
    assign in_ready = !r_s1Valid | w_s2Adv;
    assign w_s1Adv  = in_valid & in_ready;

    // Subtraction is A + ~B + 1: invert B here and feed the +1 as carry-in.
    assign w_bMod = in_sub ? ~in_b : in_b;
    assign w_g    = in_a & w_bMod;
    assign w_p    = in_a ^ w_bMod;

    always_comb begin
        w_grpG = '0;
        w_grpP = '0;
        for (int k = 0; k < NGRP; k++) begin
            {w_grpG[k], w_grpP[k]} = group_gp(w_g[k*NIB +: NIB], w_p[k*NIB +: NIB]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1Adv) begin
            r_g        <= w_g;
            r_p        <= w_p;
            r_grpG     <= w_grpG;
            r_grpP     <= w_grpP;
            r_s1.cin   <= in_sub;
            r_s1.a_msb <= in_a[WIDTH-1];
            r_s1.b_msb <= w_bMod[WIDTH-1];
        end
    end

    always_comb begin
        w_c    = '0;
        w_c[0] = r_s1.cin;
        for (int k = 0; k < NGRP; k++) begin
            w_c[k+1] = r_grpG[k] | (r_grpP[k] & w_c[k]);
        end
    end

    // Group G/P were already registered in stage 1, so the cells' own G/P go unused.
    for (genvar k = 0; k < NGRP; k++) begin : g_cla
        cla_lookahead4 u_cla (
            .g (r_g[k*NIB +: NIB]),
            .p (r_p[k*NIB +: NIB]),
            .c (w_c[k]),
            .C (w_bitC[k*NIB +: NIB]),
            .G (w_unusedG[k]),
            .P (w_unusedP[k])
        );
    end

    assign w_sum = r_p ^ w_bitC;
    assign w_ovf = (r_s1.a_msb == r_s1.b_msb) & (w_sum[WIDTH-1] != r_s1.a_msb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid  <= 1'b0;
            r_outValid <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
        end else if (flush) begin
            r_s1Valid  <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            if (w_s1Adv) begin
                r_s1Valid <= 1'b1;
            end else if (w_s2Adv) begin
                r_s1Valid <= 1'b0;
            end
            if (w_s2Adv) begin
                r_outValid <= 1'b1;
                r_sum      <= w_sum;
                r_cout     <= w_c[NGRP];
                r_ovf      <= w_ovf;
                r_zero     <= (w_sum == '0);
                r_neg      <= w_sum[WIDTH-1];
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;
    assign out_neg   = r_neg;

endmodule
